// File: rtl/mprjram_arbiter.sv
// mprjram_arbiter: shares the user-project BRAM between the Wishbone slave
// port (management core) and the local FIR/DMA engine port. One access at a
// time, round-robin between the two requesters, each access holds the BRAM
// for DELAY cycles and then returns a one-cycle acknowledge to its owner.
module mprjram_arbiter #(
    parameter int DELAY = 10,
    parameter int AW    = 12
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          eng_req,
    input  logic          eng_we,
    input  logic [AW-1:0] eng_addr,
    input  logic [31:0]   eng_wdata,
    output logic          eng_ack,
    output logic [31:0]   eng_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester identity used for grant and priority tracking.
    localparam logic SEL_WB  = 1'b0;
    localparam logic SEL_ENG = 1'b1;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;       // preferred requester on a tie
    logic          gnt_q, gnt_d;         // owner of the access in flight
    logic          we_q, we_d;           // access in flight is a write
    logic          abort_q, abort_d;     // Wishbone cycle dropped mid-access
    logic [3:0]    cnt_q, cnt_d;         // remaining ACCESS cycles minus one
    logic          ram_en_q, ram_en_d;
    logic [3:0]    ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]   ram_wdata_q, ram_wdata_d;
    logic          wbs_ack_q, wbs_ack_d;
    logic          eng_ack_q, eng_ack_d;
    logic [31:0]   wbs_dat_q, wbs_dat_d;
    logic [31:0]   eng_rdata_q, eng_rdata_d;

    logic          wb_valid;
    logic          grant_eng;
    logic          unused_adr_bits;

    // Only the 0x38xx_xxxx window belongs to this BRAM; the offset above the
    // word address is dropped so accesses wrap inside the array.
    assign wb_valid  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == 8'h38);
    assign grant_eng = eng_req & (~wb_valid | (prio_q == SEL_ENG));
    assign unused_adr_bits = ^{wbs_adr_i[23:AW+2], wbs_adr_i[1:0]};

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        abort_d     = abort_q;
        cnt_d       = cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 4'h0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        wbs_ack_d   = 1'b0;
        eng_ack_d   = 1'b0;
        wbs_dat_d   = wbs_dat_q;
        eng_rdata_d = eng_rdata_q;

        case (state_q)
            IDLE: begin
                if (wb_valid || eng_req) begin
                    state_d  = ACCESS;
                    gnt_d    = grant_eng ? SEL_ENG : SEL_WB;
                    prio_d   = grant_eng ? SEL_WB : SEL_ENG;
                    abort_d  = 1'b0;
                    cnt_d    = 4'(DELAY - 1);
                    ram_en_d = 1'b1;
                    if (grant_eng) begin
                        we_d        = eng_we;
                        ram_we_d    = eng_we ? 4'hF : 4'h0;
                        ram_addr_d  = eng_addr;
                        ram_wdata_d = eng_wdata;
                    end else begin
                        we_d        = wbs_we_i;
                        ram_we_d    = wbs_we_i ? wbs_sel_i : 4'h0;
                        ram_addr_d  = wbs_adr_i[AW+1:2];
                        ram_wdata_d = wbs_dat_i;
                    end
                end
            end

            ACCESS: begin
                // A dropped Wishbone cycle lets the BRAM access finish but
                // suppresses the acknowledge; the engine never aborts.
                abort_d = abort_q | ((gnt_q == SEL_WB) & ~wbs_cyc_i);
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (gnt_q == SEL_ENG) begin
                        eng_ack_d = 1'b1;
                        if (!we_q) eng_rdata_d = ram_rdata;
                    end else begin
                        wbs_ack_d = ~abort_d;
                        if (!we_q) wbs_dat_d = ram_rdata;
                    end
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    ram_en_d = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            prio_q      <= SEL_WB;
            gnt_q       <= SEL_WB;
            we_q        <= 1'b0;
            abort_q     <= 1'b0;
            cnt_q       <= 4'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'h0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0;
            wbs_ack_q   <= 1'b0;
            eng_ack_q   <= 1'b0;
            wbs_dat_q   <= 32'h0;
            eng_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            abort_q     <= abort_d;
            cnt_q       <= cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            wbs_ack_q   <= wbs_ack_d;
            eng_ack_q   <= eng_ack_d;
            wbs_dat_q   <= wbs_dat_d;
            eng_rdata_q <= eng_rdata_d;
        end
    end

    assign wbs_ack_o = wbs_ack_q;
    assign wbs_dat_o = wbs_dat_q;
    assign eng_ack   = eng_ack_q;
    assign eng_rdata = eng_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/mprjram_arbiter.md
# mprjram_arbiter

Arbitrates the user-project BRAM (mprjram, Wishbone window 0x3800_0000) between the Wishbone slave port, used by the management core to fetch firmware and access data, and a local engine port used by the FIR/DMA datapath. One access runs at a time. Round-robin arbitration between the two requesters. Each access holds the BRAM for a fixed programmable latency, then returns a single-cycle acknowledge to the winning requester.

## Interface
Parameters:
- `DELAY`, default 10: BRAM access cycles per transaction (1..15).
- `AW`, default 12: BRAM word-address width (4096 words = 16 KiB).

Ports:
- `wb_clk_i`  in  1  clock; the only clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`  in  1 each  Wishbone cycle/strobe.
- `wbs_we_i`  in  1  Wishbone write enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge, one-cycle pulse.
- `wbs_dat_o`  out  32  read data, valid with `wbs_ack_o`.
- `eng_req`  in  1  engine request, held until `eng_ack`.
- `eng_we`  in  1  engine write (full word).
- `eng_addr`  in  AW  engine word address.
- `eng_wdata`  in  32  engine write data.
- `eng_ack`  out  1  engine acknowledge, one-cycle pulse.
- `eng_rdata`  out  32  read data, valid with `eng_ack`.
- `ram_en`  out  1  BRAM enable.
- `ram_we`  out  4  BRAM byte write enables.
- `ram_addr`  out  AW  BRAM word address.
- `ram_wdata`  out  32  BRAM write data.
- `ram_rdata`  in  32  BRAM read data, valid after DELAY cycles of stable address.

## Operation
- Wishbone request is valid when `wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==8'h38)`. Other addresses are ignored: no ack, no BRAM access.
- Word address for Wishbone is `wbs_adr_i[AW+1:2]`. Upper offset bits are discarded, so addresses wrap inside the BRAM.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any request is valid, grant it, latch address, data, we and sel, load counter = DELAY-1, and go to ACCESS.
  - ACCESS: `ram_en`=1 with latched address and data. `ram_we` = latched sel (Wishbone) or 4'hF (engine) on the first ACCESS cycle only; it is 0 for reads and 0 after the first cycle. Decrement the counter. At 0, capture `ram_rdata` into the granted requester's data register and go to RESP.
  - RESP: pulse the granted requester's ack, then go to IDLE.
- Round-robin: a 1-bit `prio` selects the preferred requester. After every grant, `prio` points to the other requester. Reset value of `prio` = Wishbone.
- Simultaneous valid requests in IDLE: the `prio` holder wins. The loser stays pending and wins next IDLE if still requesting.
- Requesters drop their request the cycle after ack. A request still high in the IDLE that follows is treated as a new transaction.
- Wishbone abort: if `wbs_cyc_i` falls during ACCESS, the BRAM access completes (a write already issued stays written) and `wbs_ack_o` is suppressed in RESP. The engine cannot abort.
- Read data outputs hold their last captured value until the next capture. Write acks leave them unchanged.

## Timing
- Reset values: `wbs_ack_o`=0, `eng_ack`=0, `wbs_dat_o`=0, `eng_rdata`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, state=IDLE, `prio`=Wishbone.
- Request first seen in IDLE at cycle t:
  - `ram_en`=1 for cycles t+1 .. t+DELAY.
  - Data captured at end of t+DELAY.
  - Ack high in cycle t+DELAY+1.
  - IDLE at t+DELAY+2.
  - Back-to-back throughput is one access per DELAY+2 cycles.
- `ram_en`/`ram_we` deassert in RESP and IDLE. All outputs are registered.
- Reset asserted mid-ACCESS or RESP: next cycle all outputs take reset values and no ack is issued. A write enable already issued is not retracted.
- DELAY=1: ACCESS lasts exactly one cycle; ack at t+2.

## Test plan
- Wishbone write 0x3800_0010 data 0xDEADBEEF sel 4'hF, then read the same address: `ram_we`=4'hF for exactly one cycle, write ack at t+11, read `wbs_dat_o`=0xDEADBEEF with ack at t+11 (DELAY=10).
- Byte write with sel 4'b0010 to word 4: `ram_we`=4'b0010 only. A read-back shows only byte 1 changed.
- Both requests valid at once after reset: Wishbone served first, engine granted in the following IDLE, ack 12 cycles after the Wishbone ack. Repeat with both held: grants alternate.
- Wishbone address 0x3000_0000 with engine idle: no `ram_en`, no ack for 100 cycles.
- `wbs_cyc_i` dropped at ACCESS cycle 3 of a write: memory updated, no `wbs_ack_o`, next request served normally.
- `wb_rst_i` pulsed at ACCESS cycle 5 of an engine read: no `eng_ack`, all outputs at reset values, `prio` = Wishbone afterwards.
